matrix_alu_seq: RTL and testbench

Parametrised, sequential successor of the coprocessor matrix ALU, operating on NxN signed matrices of W-bit elements. Operands are latched on a start/busy/done handshake. Element-wise ops complete in one cycle; multiplication runs one output element per cycle. Selectable wrap or saturating arithmetic, with overflow and illegal-opcode reporting. Sits between the coprocessor instruction decoder and the matrix register/memory interface.

---
 rtl/matrix_alu_seq.sv | 183 ++++++++++++++++++
 tb/tb_matrix_alu_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alu_seq.sv
// Sequential NxN signed matrix ALU: element-wise ops in one cycle, multiply one
// output element per cycle, wrap or saturating reduction with overflow/illegal-op flags.
module matrix_alu_seq #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            opcode,
    input  logic                  sat_mode,
    input  logic signed [W-1:0]   scalar,
    input  logic [N*N*W-1:0]      matrix_a,
    input  logic [N*N*W-1:0]      matrix_b,
    output logic [N*N*W-1:0]      result,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic                  err
);
    localparam int EL    = N * N;
    localparam int MW    = EL * W;
    localparam int ACC_W = 2 * W + $clog2(N);
    localparam int IDX_W = (EL > 1) ? $clog2(EL) : 1;
    localparam int MAXI  = 2 ** (W - 1) - 1;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(MAXI);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(EL - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_TRN = 4'b0110;
    localparam logic [3:0] OP_NEG = 4'b0111;
    localparam logic [3:0] OP_SCL = 4'b1000;

    logic [1:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [MW-1:0]           a_r, b_r;
    logic signed [W-1:0]     s_r;
    logic [3:0]              op_r;
    logic                    sat_r;
    logic                    ovf_acc;
    logic [MW-1:0]           ew_res;
    logic                    ew_ovf;
    logic signed [ACC_W-1:0] acc;
    int                      mi, mj;

    function automatic logic signed [W-1:0] el(input logic [MW-1:0] m, input int i, input int j);
        return m[(i*N+j)*W +: W];
    endfunction

    function automatic logic fits(input logic signed [ACC_W-1:0] x);
        return (x >= MINV) && (x <= MAXV);
    endfunction

    function automatic logic [W-1:0] reduce(input logic signed [ACC_W-1:0] x, input logic sat);
        if (sat && (x > MAXV)) return MAXV[W-1:0];
        if (sat && (x < MINV)) return MINV[W-1:0];
        return x[W-1:0];
    endfunction

    function automatic logic legal_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_TRN) || (op == OP_NEG) || (op == OP_SCL);
    endfunction

    // Exact value at ACC_W, which is wide enough for every element-wise op.
    function automatic logic signed [ACC_W-1:0] ew_exact(
        input logic [3:0] op, input logic signed [W-1:0] a, input logic signed [W-1:0] b,
        input logic signed [W-1:0] at, input logic signed [W-1:0] s);
        logic signed [ACC_W-1:0] ae, be, te, se;
        ae = a;
        be = b;
        te = at;
        se = s;
        case (op)
            OP_ADD:  return ae + be;
            OP_SUB:  return ae - be;
            OP_TRN:  return te;
            OP_NEG:  return -ae;
            OP_SCL:  return ae * se;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] mulp(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
        logic signed [ACC_W-1:0] ae, be;
        ae = a;
        be = b;
        return ae * be;
    endfunction

    always_comb begin
        ew_res = '0;
        ew_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ew_res[(i*N+j)*W +: W] = reduce(ew_exact(op_r, el(a_r, i, j), el(b_r, i, j),
                                                         el(a_r, j, i), s_r), sat_r);
                ew_ovf = ew_ovf | ~fits(ew_exact(op_r, el(a_r, i, j), el(b_r, i, j),
                                                 el(a_r, j, i), s_r));
            end
        end
    end

    // Dot product for the output element currently addressed by idx.
    always_comb begin
        mi  = int'(idx) / N;
        mj  = int'(idx) % N;
        acc = '0;
        for (int k = 0; k < N; k++) begin
            acc = acc + mulp(el(a_r, mi, k), el(b_r, k, mj));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            op_r    <= '0;
            sat_r   <= 1'b0;
            ovf_acc <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            ovf  <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r     <= matrix_a;
                        b_r     <= matrix_b;
                        s_r     <= scalar;
                        op_r    <= opcode;
                        sat_r   <= sat_mode;
                        ovf_acc <= 1'b0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= (opcode == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (legal_op(op_r)) begin
                        result <= ew_res;
                        ovf    <= ew_ovf;
                    end else begin
                        err <= 1'b1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_MUL: begin
                    result[int'(idx)*W +: W] <= reduce(acc, sat_r);
                    if (idx == LAST) begin
                        ovf   <= ovf_acc | ~fits(acc);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        idx   <= '0;
                        state <= S_IDLE;
                    end else begin
                        ovf_acc <= ovf_acc | ~fits(acc);
                        idx     <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_alu_seq.sv
// Directed bench for matrix_alu_seq: scoreboard of modelled results, checked on each done pulse.
module tb_matrix_alu_seq;
    localparam int N   = 5;
    localparam int W   = 8;
    localparam int MW  = N * N * W;
    localparam int MW2 = 3 * 3 * 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                start, sat_mode, busy, done, ovf, err;
    logic [3:0]          opcode;
    logic signed [W-1:0] scalar;
    logic [MW-1:0]       matrix_a, matrix_b, result;

    logic                start2, sat2, busy2, done2, ovf2, err2;
    logic [3:0]          opcode2;
    logic signed [11:0]  scalar2;
    logic [MW2-1:0]      a2, b2, result2;

    matrix_alu_seq #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .sat_mode(sat_mode),
        .scalar(scalar), .matrix_a(matrix_a), .matrix_b(matrix_b), .result(result),
        .busy(busy), .done(done), .ovf(ovf), .err(err));

    matrix_alu_seq #(.N(3), .W(12)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .opcode(opcode2), .sat_mode(sat2),
        .scalar(scalar2), .matrix_a(a2), .matrix_b(b2), .result(result2),
        .busy(busy2), .done(done2), .ovf(ovf2), .err(err2));

    typedef struct {
        logic [MW-1:0] res;
        bit            ovf;
        bit            err;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [MW-1:0] prev_res;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int ga(input logic [MW-1:0] m, input int i, input int j);
        logic signed [7:0] t;
        t = m[(i*N+j)*W +: W];
        return int'(t);
    endfunction

    function automatic logic [MW-1:0] fill(input int v);
        logic [MW-1:0] r;
        logic [7:0]    b;
        b = v[7:0];
        for (int e = 0; e < N * N; e++) r[e*8 +: 8] = b;
        return r;
    endfunction

    function automatic logic [MW-1:0] seq(input int base);
        logic [MW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*8 +: 8] = 8'(e + base);
        return r;
    endfunction

    function automatic logic [MW-1:0] ident();
        logic [MW-1:0] r;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) r[(i*N+j)*8 +: 8] = (i == j) ? 8'd1 : 8'd0;
        return r;
    endfunction

    // Reference: exact integer value per element, then range check and wrap/clip.
    function automatic void model(input logic [3:0] op, input bit sat, input int sc,
                                  input logic [MW-1:0] a, input logic [MW-1:0] b,
                                  input logic [MW-1:0] prev, output logic [MW-1:0] r,
                                  output bit o, output bit e);
        int x;
        r = prev;
        o = 1'b0;
        e = !(op inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8});
        if (e) return;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (op)
                    4'd3: x = ga(a, i, j) + ga(b, i, j);
                    4'd4: x = ga(a, i, j) - ga(b, i, j);
                    4'd5: begin
                        x = 0;
                        for (int k = 0; k < N; k++) x += ga(a, i, k) * ga(b, k, j);
                    end
                    4'd6: x = ga(a, j, i);
                    4'd7: x = -ga(a, i, j);
                    default: x = ga(a, i, j) * sc;
                endcase
                if (x > 127 || x < -128) begin
                    o = 1'b1;
                    if (sat) x = (x > 127) ? 127 : -128;
                end
                r[(i*N+j)*8 +: 8] = x[7:0];
            end
        end
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input bit sat, input int sc,
                          input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input int exp_cyc, input int glitch);
        exp_t e;
        int   cyc, bcnt;
        model(op, sat, sc, a, b, prev_res, e.res, e.ovf, e.err);
        sb.push_back(e);
        prev_res = e.res;
        opcode   = op;
        sat_mode = sat;
        scalar   = sc[7:0];
        matrix_a = a;
        matrix_b = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_at_start"}, busy, 1);
        check({tag, "_ovf_idle"}, ovf, 0);
        bcnt = 1;
        cyc  = 0;
        while (!done && cyc < 100) begin
            if (cyc == glitch) begin
                start    = 1'b1;
                opcode   = 4'b0011;
                matrix_a = ~a;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, "_result"}, result, e.res);
        check({tag, "_ovf"}, ovf, e.ovf);
        check({tag, "_err"}, err, e.err);
        check({tag, "_latency"}, cyc, exp_cyc);
        check({tag, "_busy_cycles"}, bcnt, exp_cyc);
    endtask

    task automatic run2(input bit sat, input logic [MW2-1:0] a, input logic [MW2-1:0] b,
                        output int cyc);
        opcode2 = 4'b0101;
        sat2    = sat;
        a2      = a;
        b2      = b;
        start2  = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc    = 0;
        while (!done2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int            extra, cyc2;
        logic [MW2-1:0] id3, sq3, all30;
        rst = 1'b1;
        start = 1'b0; opcode = '0; sat_mode = 1'b0; scalar = '0;
        matrix_a = '0; matrix_b = '0;
        start2 = 1'b0; opcode2 = '0; sat2 = 1'b0; scalar2 = '0; a2 = '0; b2 = '0;
        prev_res = '0;
        @(posedge clk); #1;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add_wrap", 4'b0011, 0, 0, fill(100), fill(100), 1, -1);
        check("add_wrap_elem", result[7:0], 8'hC8);
        run_op("add_sat", 4'b0011, 1, 0, fill(100), fill(100), 1, -1);
        check("add_sat_elem", result[MW-1 -: 8], 8'h7F);
        run_op("mul_ident", 4'b0101, 0, 0, ident(), seq(1), 25, -1);
        check("mul_ident_eq_b", result, seq(1));
        run_op("mul10_wrap", 4'b0101, 0, 0, fill(10), fill(10), 25, -1);
        check("mul10_wrap_elem", result[7:0], 8'hF4);
        run_op("mul10_sat", 4'b0101, 1, 0, fill(10), fill(10), 25, -1);
        check("mul10_sat_elem", result[7:0], 8'h7F);
        run_op("neg_wrap", 4'b0111, 0, 0, fill(-128), fill(0), 1, -1);
        check("neg_wrap_elem", result[7:0], 8'h80);
        run_op("neg_sat", 4'b0111, 1, 0, fill(-128), fill(0), 1, -1);
        check("neg_sat_elem", result[7:0], 8'h7F);
        run_op("transpose", 4'b0110, 0, 0, seq(0), fill(0), 1, -1);
        check("transpose_1_2", result[(1*5+2)*8 +: 8], 8'd11);
        run_op("sub_sat", 4'b0100, 1, 0, fill(-100), fill(100), 1, -1);
        run_op("scalar_sat", 4'b1000, 1, -3, fill(50), fill(0), 1, -1);
        check("scalar_sat_elem", result[7:0], 8'h80);
        run_op("illegal", 4'b0000, 0, 0, fill(1), fill(1), 1, -1);
        check("illegal_unchanged", result, fill(-128));

        // Abort a multiply after ten elements have been written.
        opcode = 4'b0101; sat_mode = 1'b0; matrix_a = ident(); matrix_b = seq(1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("partial_mul", result[79:0], seq(1) & {{(MW-80){1'b0}}, {80{1'b1}}});
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_result", result, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        check("abort_no_done", done, 0);
        rst = 1'b0;
        prev_res = '0;
        run_op("add_after_rst", 4'b0011, 0, 0, seq(1), seq(1), 1, -1);
        run_op("mul_glitch", 4'b0101, 0, 0, ident(), seq(1), 25, 5);
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("no_extra_done", extra, 0);

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                id3[(i*3+j)*12 +: 12]   = (i == j) ? 12'd1 : 12'd0;
                sq3[(i*3+j)*12 +: 12]   = 12'(i * 3 + j + 1);
                all30[(i*3+j)*12 +: 12] = 12'd30;
            end
        end
        run2(0, id3, sq3, cyc2);
        check("n3_latency", cyc2, 9);
        check("n3_result", result2, sq3);
        check("n3_elem_2_1", result2[84 +: 12], 12'd8);
        check("n3_ovf", ovf2, 0);
        run2(1, all30, all30, cyc2);
        check("n3_sat_elem", result2[84 +: 12], 12'h7FF);
        check("n3_sat_ovf", ovf2, 1);
        run2(0, all30, all30, cyc2);
        check("n3_wrap_elem", result2[84 +: 12], 12'hA8C);
        check("n3_wrap_ovf", ovf2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
